// File: rtl/kv_op_sequencer.sv
// kv_op_sequencer
//  Sequences search / insert / transact operations on a two-table key/value
//  BRAM store (table 1 = lower half of the address space, table 2 = upper
//  half). Takes one request at a time, drives the external hash unit with a
//  registered key, issues single-cycle-latency BRAM reads and writes, and
//  returns status, value and slot address over a valid/ready response port.
//  Every output is driven straight from a register.
//
//  Optional feature macro: KV_SEQ_STATS_EN
//    When defined, adds stat_ops / stat_fails saturating response counters.
module kv_op_sequencer #(
    parameter int                   RAM_ADDR_BITS = 9,
    parameter int                   KEY_WIDTH     = 32,
    parameter int                   VAL_WIDTH     = 32,
    parameter logic [KEY_WIDTH-1:0] EMPTY_KEY     = '0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [KEY_WIDTH-1:0]     req_key,
    input  logic [VAL_WIDTH-1:0]     req_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [2:0]               rsp_status,
    output logic [VAL_WIDTH-1:0]     rsp_value,
    output logic [RAM_ADDR_BITS-1:0] rsp_addr,
    output logic [KEY_WIDTH-1:0]     hash_key,
    input  logic [31:0]              hash1,
    input  logic [31:0]              hash2,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [RAM_ADDR_BITS-1:0] ram_addr,
    output logic [KEY_WIDTH-1:0]     ram_key_wdata,
    output logic [VAL_WIDTH-1:0]     ram_val_wdata,
    input  logic [KEY_WIDTH-1:0]     ram_key_rdata,
    input  logic [VAL_WIDTH-1:0]     ram_val_rdata
`ifdef KV_SEQ_STATS_EN
    ,
    output logic [15:0]              stat_ops,
    output logic [15:0]              stat_fails
`endif
);

    localparam int A = RAM_ADDR_BITS;

    localparam logic [1:0] OP_SEARCH   = 2'd0;
    localparam logic [1:0] OP_INSERT   = 2'd1;
    localparam logic [1:0] OP_TRANSACT = 2'd2;
    localparam logic [1:0] OP_RESERVED = 2'd3;

    localparam logic [2:0] RS_OK        = 3'd0;
    localparam logic [2:0] RS_NOT_FOUND = 3'd1;
    localparam logic [2:0] RS_FULL      = 3'd2;
    localparam logic [2:0] RS_INSUFF    = 3'd3;
    localparam logic [2:0] RS_BAD_OP    = 3'd4;
    localparam logic [2:0] RS_BAD_KEY   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HASH = 3'd1,
        ST_RD1  = 3'd2,
        ST_CHK1 = 3'd3,
        ST_RD2  = 3'd4,
        ST_CHK2 = 3'd5,
        ST_WR   = 3'd6,
        ST_RSP  = 3'd7
    } state_t;

    // Registered state and outputs
    state_t               state_r,         state_s;
    logic [1:0]           op_r,            op_s;
    logic [KEY_WIDTH-1:0] key_r,           key_s;
    logic [VAL_WIDTH-1:0] data_r,          data_s;
    logic [A-1:0]         idx1_r,          idx1_s;
    logic [A-1:0]         idx2_r,          idx2_s;
    logic                 hit1_r,          hit1_s;
    logic                 empty1_r,        empty1_s;
    logic                 req_ready_r,     req_ready_s;
    logic                 rsp_valid_r,     rsp_valid_s;
    logic [2:0]           rsp_status_r,    rsp_status_s;
    logic [VAL_WIDTH-1:0] rsp_value_r,     rsp_value_s;
    logic [A-1:0]         rsp_addr_r,      rsp_addr_s;
    logic [KEY_WIDTH-1:0] hash_key_r,      hash_key_s;
    logic                 ram_en_r,        ram_en_s;
    logic                 ram_we_r,        ram_we_s;
    logic [A-1:0]         ram_addr_r,      ram_addr_s;
    logic [KEY_WIDTH-1:0] ram_key_wdata_r, ram_key_wdata_s;
    logic [VAL_WIDTH-1:0] ram_val_wdata_r, ram_val_wdata_s;

    // Probe evaluation helpers
    logic                 rd_hit_s;
    logic                 rd_empty_s;
    logic [A-1:0]         cur_idx_s;
    logic                 tx_ok_s;
    logic [VAL_WIDTH-1:0] tx_val_s;
    logic                 hit_wr_s;
    logic [2:0]           hit_status_s;
    logic [VAL_WIDTH-1:0] hit_value_s;

    // Decision outcome of the current cycle
    logic                 wr_go_s;
    logic [A-1:0]         wr_addr_s;
    logic [VAL_WIDTH-1:0] wr_val_s;
    logic                 fin_go_s;
    logic [2:0]           fin_status_s;
    logic [VAL_WIDTH-1:0] fin_value_s;
    logic [A-1:0]         fin_addr_s;

    // Only the low index bits of each hash are consumed
    logic unused_hash_s;
    assign unused_hash_s = ^{hash1[31:A-1], hash2[31:A-1]};

    assign req_ready     = req_ready_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_status    = rsp_status_r;
    assign rsp_value     = rsp_value_r;
    assign rsp_addr      = rsp_addr_r;
    assign hash_key      = hash_key_r;
    assign ram_en        = ram_en_r;
    assign ram_we        = ram_we_r;
    assign ram_addr      = ram_addr_r;
    assign ram_key_wdata = ram_key_wdata_r;
    assign ram_val_wdata = ram_val_wdata_r;

    // Compare the slot read in the previous cycle against the latched key
    always_comb begin
        rd_hit_s   = (ram_key_rdata == key_r);
        rd_empty_s = (ram_key_rdata == EMPTY_KEY);
        tx_ok_s    = (data_r <= ram_val_rdata);
        tx_val_s   = ram_val_rdata - data_r;
        if (state_r == ST_CHK2) begin
            cur_idx_s = idx2_r;
        end else begin
            cur_idx_s = idx1_r;
        end
    end

    // What a key hit on the slot just read turns into, per operation
    always_comb begin
        hit_wr_s     = 1'b0;
        hit_status_s = RS_OK;
        hit_value_s  = ram_val_rdata;
        if (op_r == OP_TRANSACT) begin
            if (tx_ok_s) begin
                hit_wr_s    = 1'b1;
                hit_value_s = tx_val_s;
            end else begin
                hit_status_s = RS_INSUFF;
                hit_value_s  = '0;
            end
        end else if (op_r == OP_INSERT) begin
            hit_wr_s    = 1'b1;
            hit_value_s = data_r;
        end else begin
            hit_wr_s = 1'b0;
        end
    end

    // Next-state and next-output logic of the sequencer FSM
    always_comb begin
        state_s         = state_r;
        op_s            = op_r;
        key_s           = key_r;
        data_s          = data_r;
        idx1_s          = idx1_r;
        idx2_s          = idx2_r;
        hit1_s          = hit1_r;
        empty1_s        = empty1_r;
        rsp_valid_s     = rsp_valid_r;
        rsp_status_s    = rsp_status_r;
        rsp_value_s     = rsp_value_r;
        rsp_addr_s      = rsp_addr_r;
        hash_key_s      = hash_key_r;
        ram_en_s        = 1'b0;
        ram_we_s        = 1'b0;
        ram_addr_s      = '0;
        ram_key_wdata_s = '0;
        ram_val_wdata_s = '0;
        wr_go_s         = 1'b0;
        wr_addr_s       = '0;
        wr_val_s        = '0;
        fin_go_s        = 1'b0;
        fin_status_s    = RS_OK;
        fin_value_s     = '0;
        fin_addr_s      = '0;

        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready_r) begin
                    op_s   = req_op;
                    key_s  = req_key;
                    data_s = req_data;
                    if (req_op == OP_RESERVED) begin
                        fin_go_s     = 1'b1;
                        fin_status_s = RS_BAD_OP;
                    end else if (req_key == EMPTY_KEY) begin
                        fin_go_s     = 1'b1;
                        fin_status_s = RS_BAD_KEY;
                    end else begin
                        hash_key_s = req_key;
                        state_s    = ST_HASH;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HASH: begin
                // Table 1 lives in the lower half, table 2 in the upper half
                idx1_s     = {1'b0, hash1[A-2:0]};
                idx2_s     = {1'b1, hash2[A-2:0]};
                ram_en_s   = 1'b1;
                ram_addr_s = {1'b0, hash1[A-2:0]};
                state_s    = ST_RD1;
            end
            ST_RD1: begin
                state_s = ST_CHK1;
            end
            ST_CHK1: begin
                hit1_s   = rd_hit_s;
                empty1_s = rd_empty_s;
                if (rd_hit_s && (op_r != OP_INSERT)) begin
                    if (hit_wr_s) begin
                        wr_go_s   = 1'b1;
                        wr_addr_s = cur_idx_s;
                        wr_val_s  = hit_value_s;
                    end else begin
                        fin_go_s     = 1'b1;
                        fin_status_s = hit_status_s;
                        fin_value_s  = hit_value_s;
                        fin_addr_s   = (hit_status_s == RS_OK) ? cur_idx_s : '0;
                    end
                end else begin
                    ram_en_s   = 1'b1;
                    ram_addr_s = idx2_r;
                    state_s    = ST_RD2;
                end
            end
            ST_RD2: begin
                state_s = ST_CHK2;
            end
            ST_CHK2: begin
                if (op_r == OP_INSERT) begin
                    // Existing key wins over any empty slot; table 1 preferred
                    if (hit1_r) begin
                        wr_go_s   = 1'b1;
                        wr_addr_s = idx1_r;
                        wr_val_s  = data_r;
                    end else if (rd_hit_s) begin
                        wr_go_s   = 1'b1;
                        wr_addr_s = idx2_r;
                        wr_val_s  = data_r;
                    end else if (empty1_r) begin
                        wr_go_s   = 1'b1;
                        wr_addr_s = idx1_r;
                        wr_val_s  = data_r;
                    end else if (rd_empty_s) begin
                        wr_go_s   = 1'b1;
                        wr_addr_s = idx2_r;
                        wr_val_s  = data_r;
                    end else begin
                        fin_go_s     = 1'b1;
                        fin_status_s = RS_FULL;
                    end
                end else if (rd_hit_s) begin
                    if (hit_wr_s) begin
                        wr_go_s   = 1'b1;
                        wr_addr_s = cur_idx_s;
                        wr_val_s  = hit_value_s;
                    end else begin
                        fin_go_s     = 1'b1;
                        fin_status_s = hit_status_s;
                        fin_value_s  = hit_value_s;
                        fin_addr_s   = (hit_status_s == RS_OK) ? cur_idx_s : '0;
                    end
                end else begin
                    fin_go_s     = 1'b1;
                    fin_status_s = RS_NOT_FOUND;
                end
            end
            ST_WR: begin
                state_s = ST_RSP;
            end
            ST_RSP: begin
                if (!rsp_valid_r) begin
                    rsp_valid_s = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_s  = 1'b0;
                    rsp_status_s = RS_OK;
                    rsp_value_s  = '0;
                    rsp_addr_s   = '0;
                    state_s      = ST_IDLE;
                end else begin
                    rsp_valid_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (wr_go_s) begin
            state_s         = ST_WR;
            ram_en_s        = 1'b1;
            ram_we_s        = 1'b1;
            ram_addr_s      = wr_addr_s;
            ram_key_wdata_s = key_r;
            ram_val_wdata_s = wr_val_s;
            rsp_status_s    = RS_OK;
            rsp_value_s     = wr_val_s;
            rsp_addr_s      = wr_addr_s;
        end else if (fin_go_s) begin
            state_s      = ST_RSP;
            rsp_status_s = fin_status_s;
            rsp_value_s  = fin_value_s;
            rsp_addr_s   = fin_addr_s;
        end else begin
            state_s = state_s;
        end

        req_ready_s = (state_s == ST_IDLE);
    end

    // State, latched request and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            op_r            <= 2'd0;
            key_r           <= '0;
            data_r          <= '0;
            idx1_r          <= '0;
            idx2_r          <= '0;
            hit1_r          <= 1'b0;
            empty1_r        <= 1'b0;
            req_ready_r     <= 1'b1;
            rsp_valid_r     <= 1'b0;
            rsp_status_r    <= 3'd0;
            rsp_value_r     <= '0;
            rsp_addr_r      <= '0;
            hash_key_r      <= '0;
            ram_en_r        <= 1'b0;
            ram_we_r        <= 1'b0;
            ram_addr_r      <= '0;
            ram_key_wdata_r <= '0;
            ram_val_wdata_r <= '0;
        end else begin
            state_r         <= state_s;
            op_r            <= op_s;
            key_r           <= key_s;
            data_r          <= data_s;
            idx1_r          <= idx1_s;
            idx2_r          <= idx2_s;
            hit1_r          <= hit1_s;
            empty1_r        <= empty1_s;
            req_ready_r     <= req_ready_s;
            rsp_valid_r     <= rsp_valid_s;
            rsp_status_r    <= rsp_status_s;
            rsp_value_r     <= rsp_value_s;
            rsp_addr_r      <= rsp_addr_s;
            hash_key_r      <= hash_key_s;
            ram_en_r        <= ram_en_s;
            ram_we_r        <= ram_we_s;
            ram_addr_r      <= ram_addr_s;
            ram_key_wdata_r <= ram_key_wdata_s;
            ram_val_wdata_r <= ram_val_wdata_s;
        end
    end

`ifdef KV_SEQ_STATS_EN
    logic [15:0] stat_ops_r;
    logic [15:0] stat_fails_r;
    logic        rsp_fire_s;

    assign rsp_fire_s = (state_r == ST_RSP) && rsp_valid_r && rsp_ready;
    assign stat_ops   = stat_ops_r;
    assign stat_fails = stat_fails_r;

    // Saturating counters of accepted responses and of failed ones
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_ops_r   <= 16'd0;
            stat_fails_r <= 16'd0;
        end else if (rsp_fire_s) begin
            if (stat_ops_r != 16'hFFFF) begin
                stat_ops_r <= stat_ops_r + 16'd1;
            end else begin
                stat_ops_r <= stat_ops_r;
            end
            if ((rsp_status_r != RS_OK) && (stat_fails_r != 16'hFFFF)) begin
                stat_fails_r <= stat_fails_r + 16'd1;
            end else begin
                stat_fails_r <= stat_fails_r;
            end
        end else begin
            stat_ops_r   <= stat_ops_r;
            stat_fails_r <= stat_fails_r;
        end
    end
`endif

endmodule

// File: tb/tb_kv_op_sequencer.sv
// Directed bench for kv_op_sequencer: a behavioural BRAM and hash unit,
// expected responses queued at request time and compared when the response
// arrives.
module tb_kv_op_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_key = 32'd0;
    logic [31:0] req_data = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [2:0]  rsp_status;
    logic [31:0] rsp_value;
    logic [8:0]  rsp_addr;
    logic [31:0] hash_key;
    logic [31:0] hash1;
    logic [31:0] hash2;
    logic        ram_en;
    logic        ram_we;
    logic [8:0]  ram_addr;
    logic [31:0] ram_key_wdata;
    logic [31:0] ram_val_wdata;
    logic [31:0] ram_key_rdata = 32'd0;
    logic [31:0] ram_val_rdata = 32'd0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [2:0]  st;
        logic [31:0] val;
        logic [8:0]  addr;
        int          lat;
        int          en;
        int          wr;
    } exp_t;
    exp_t sb_q[$];

    logic [31:0] mem_key [0:511] = '{default: 32'h0};
    logic [31:0] mem_val [0:511] = '{default: 32'h0};
    int wr_count = 0;
    int en_count = 0;

    kv_op_sequencer dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_key(req_key), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_value(rsp_value), .rsp_addr(rsp_addr),
        .hash_key(hash_key), .hash1(hash1), .hash2(hash2),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_key_wdata(ram_key_wdata), .ram_val_wdata(ram_val_wdata),
        .ram_key_rdata(ram_key_rdata), .ram_val_rdata(ram_val_rdata)
    );

    always #5 clock = ~clock;

    // Hash unit: key 0x11 -> idx1 3, idx2 256+3; 0x10011/0x20011 collide with it
    assign hash1 = hash_key ^ 32'h0000_0012;
    assign hash2 = (hash_key >> 8) ^ 32'h0000_0003;

    // BRAM model with one-cycle read latency
    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_we) begin
                mem_key[ram_addr] <= ram_key_wdata;
                mem_val[ram_addr] <= ram_val_wdata;
                wr_count <= wr_count + 1;
            end else begin
                ram_key_rdata <= mem_key[ram_addr];
                ram_val_rdata <= mem_val[ram_addr];
            end
            en_count <= en_count + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] key,
                         input logic [31:0] data, input logic [2:0] st, input logic [31:0] val,
                         input logic [8:0] addr, input int lat, input int en, input int wr,
                         input int hold);
        exp_t e;
        int   n;
        int   en0;
        int   wr0;
        e.st = st; e.val = val; e.addr = addr; e.lat = lat; e.en = en; e.wr = wr;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clock); #1; n++;
        end
        check({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
        en0 = en_count;
        wr0 = wr_count;
        req_op = op; req_key = key; req_data = data; req_valid = 1'b1;
        sb_q.push_back(e);
        @(posedge clock); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clock); #1; n++;
        end
        check({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
        e = sb_q.pop_front();
        check({tag, "_status"}, {61'd0, rsp_status}, {61'd0, e.st});
        check({tag, "_value"}, {32'd0, rsp_value}, {32'd0, e.val});
        check({tag, "_addr"}, {55'd0, rsp_addr}, {55'd0, e.addr});
        if (e.lat >= 0) check({tag, "_latency"}, 64'(n), 64'(e.lat));
        if (e.en >= 0) check({tag, "_ram_en_cycles"}, 64'(en_count - en0), 64'(e.en));
        check({tag, "_writes"}, 64'(wr_count - wr0), 64'(e.wr));
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check({tag, "_hold"}, {18'd0, rsp_valid, req_ready, rsp_status, rsp_value, rsp_addr},
                  {18'd0, 1'b1, 1'b0, e.st, e.val, e.addr});
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, {62'd0, rsp_valid, req_ready}, {62'd0, 1'b0, 1'b1});
    endtask

    initial begin : stim
        exp_t dummy;
        int   n;
        logic seen;
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", {rsp_valid, req_ready, ram_en, ram_we, rsp_status, rsp_value, rsp_addr},
              {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 9'd0});
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        check("idle_ready", {63'd0, req_ready}, 64'd1);

        // ops: 0 search, 1 insert, 2 transact, 3 reserved
        do_op("ins_11", 2'd1, 32'h11, 32'd5, 3'd0, 32'd5, 9'd3, 7, 3, 1, 0);
        check("mem_key3", {32'd0, mem_key[3]}, 64'h11);
        check("mem_val3", {32'd0, mem_val[3]}, 64'd5);
        do_op("srch_11", 2'd0, 32'h11, 32'd0, 3'd0, 32'd5, 9'd3, 4, 1, 0, 0);
        do_op("ins_10011", 2'd1, 32'h10011, 32'd9, 3'd0, 32'd9, 9'd259, 7, 3, 1, 0);
        do_op("srch_10011", 2'd0, 32'h10011, 32'd0, 3'd0, 32'd9, 9'd259, 6, 2, 0, 0);
        do_op("ovw_10011", 2'd1, 32'h10011, 32'hA, 3'd0, 32'hA, 9'd259, 7, 3, 1, 0);
        check("mem_val259", {32'd0, mem_val[259]}, 64'hA);
        do_op("ins_full", 2'd1, 32'h20011, 32'd1, 3'd2, 32'd0, 9'd0, 6, 2, 0, 0);
        do_op("srch_miss", 2'd0, 32'h30011, 32'd0, 3'd1, 32'd0, 9'd0, 6, 2, 0, 0);
        do_op("tx_insuff", 2'd2, 32'h11, 32'd7, 3'd3, 32'd0, 9'd0, -1, -1, 0, 0);
        do_op("tx_exact", 2'd2, 32'h11, 32'd5, 3'd0, 32'd0, 9'd3, -1, -1, 1, 0);
        check("mem_val3_tx", {32'd0, mem_val[3]}, 64'd0);
        do_op("tx_t2", 2'd2, 32'h10011, 32'd3, 3'd0, 32'd7, 9'd259, 7, 3, 1, 0);
        do_op("tx_miss", 2'd2, 32'h30011, 32'd1, 3'd1, 32'd0, 9'd0, 6, 2, 0, 0);
        do_op("bad_op", 2'd3, 32'h11, 32'd0, 3'd4, 32'd0, 9'd0, 1, 0, 0, 0);
        do_op("bad_key", 2'd0, 32'h0, 32'd0, 3'd5, 32'd0, 9'd0, 1, 0, 0, 0);
        do_op("srch_hold", 2'd0, 32'h11, 32'd0, 3'd0, 32'd0, 9'd3, 4, 1, 0, 10);

        // Reset pulse during the table-2 read aborts the op with no response
        dummy.st = 3'd1; dummy.val = 32'd0; dummy.addr = 9'd0;
        dummy.lat = 6; dummy.en = 2; dummy.wr = 0;
        req_op = 2'd0; req_key = 32'h30011; req_data = 32'd0; req_valid = 1'b1;
        sb_q.push_back(dummy);
        @(posedge clock); #1;
        req_valid = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            @(posedge clock); #1; n++;
            seen = ram_en && ram_addr[8];
        end
        check("rd2_reached", {63'd0, seen}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_reset_outputs", {rsp_valid, req_ready, ram_en, ram_we, rsp_status, rsp_value, rsp_addr},
              {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 9'd0});
        sb_q.delete();
        @(negedge clock) reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (rsp_valid || ram_we) seen = 1'b1;
        end
        check("no_rsp_after_abort", {63'd0, seen}, 64'd0);
        check("idle_after_abort", {63'd0, req_ready}, 64'd1);
        do_op("srch_post_rst", 2'd0, 32'h10011, 32'd0, 3'd0, 32'd7, 9'd259, 6, 2, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
